// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS receive checker with lock FSM and BER counters
// Optional feature macro: PRBS_OVERLAP_CHK_EN (adds word-to-word overlap check and prev_word register)

module prbs_checker #(
   parameter int BITS_WIDTH = 5,
   parameter int TAP_A      = 1,
   parameter int TAP_B      = 4,
   parameter int INVERT     = 1,
   parameter int LOCK_CNT   = 16,
   parameter int LOSS_CNT   = 8,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BITS_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   input  logic                  clr_cnt,
   output logic                  locked,
   output logic                  err_pulse,
   output logic [CNT_W-1:0]      err_count,
   output logic [CNT_W-1:0]      bit_count
);

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam int   FILL_W  = $clog2(TAP_B + 1);
   localparam int   GOOD_W  = $clog2(LOCK_CNT + 1);
   localparam int   BAD_W   = $clog2(LOSS_CNT + 1);
   localparam logic INV_BIT = (INVERT != 0);

   // Received-bit history, hist[0] is the most recent bit
   logic [TAP_B-1:0]  hist;
   logic [FILL_W-1:0] fill_cnt;
   logic [GOOD_W-1:0] good_cnt;
   logic [GOOD_W-1:0] good_nxt;
   logic [BAD_W-1:0]  bad_cnt;
   logic [BAD_W-1:0]  bad_nxt;
   state_t            state;
   state_t            state_nxt;

   logic new_bit;
   logic exp_bit;
   logic live;
   logic rec_bad;
   logic ovl_bad;
   logic mismatch;
   logic cnt_bit;
   logic cnt_err;

   assign new_bit = data_in[BITS_WIDTH-1];
   assign exp_bit = (hist[TAP_A-1] ^ hist[TAP_B-1]) ^ INV_BIT;
   assign rec_bad = (new_bit != exp_bit);

   // A prediction only means something once the history is completely filled
   assign live     = data_valid && (fill_cnt == FILL_W'(TAP_B));
   assign mismatch = live && (rec_bad || ovl_bad);

`ifdef PRBS_OVERLAP_CHK_EN
   logic [BITS_WIDTH-1:0] prev_word;

   // The shifted-down part of this word must equal the upper part of the last word
   assign ovl_bad = (data_in[BITS_WIDTH-2:0] != prev_word[BITS_WIDTH-1:1]);

   // Remember the last valid word for the overlap comparison
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_word <= '0;
      end else if (data_valid) begin
         prev_word <= data_in;
      end
   end
`else
   logic unused_low_bits;

   // Only the newest bit of each word is needed without the overlap check
   assign ovl_bad         = 1'b0;
   assign unused_low_bits = ^data_in[BITS_WIDTH-2:0];
`endif

   // History always follows the received stream, locked or not, so it self-synchronises
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist <= '0;
      end else if (data_valid) begin
         hist <= {hist[TAP_B-2:0], new_bit};
      end
   end

   // Count words into the history until it is full, then hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_cnt <= '0;
      end else if (data_valid && (fill_cnt != FILL_W'(TAP_B))) begin
         fill_cnt <= fill_cnt + FILL_W'(1);
      end
   end

   // State and run-length counters register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= HUNT;
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_nxt;
         bad_cnt  <= bad_nxt;
      end
   end

   // Lock acquisition / loss decisions and counter enables for the current word
   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      bad_nxt   = bad_cnt;
      cnt_bit   = 1'b0;
      cnt_err   = 1'b0;
      if (live) begin
         case (state)
            HUNT: begin
               if (mismatch) begin
                  good_nxt = '0;
               end else if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                  // The word that completes the good run is not itself counted
                  state_nxt = LOCK;
                  good_nxt  = '0;
                  bad_nxt   = '0;
               end else begin
                  good_nxt = good_cnt + GOOD_W'(1);
               end
            end
            LOCK: begin
               cnt_bit = 1'b1;
               if (mismatch) begin
                  cnt_err  = 1'b1;
                  good_nxt = '0;
                  if (bad_cnt == BAD_W'(LOSS_CNT - 1)) begin
                     state_nxt = HUNT;
                     bad_nxt   = '0;
                  end else begin
                     bad_nxt = bad_cnt + BAD_W'(1);
                  end
               end else if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                  // A full good run forgives earlier scattered errors
                  good_nxt = '0;
                  bad_nxt  = '0;
               end else begin
                  good_nxt = good_cnt + GOOD_W'(1);
               end
            end
            default: begin
               state_nxt = HUNT;
               good_nxt  = '0;
               bad_nxt   = '0;
            end
         endcase
      end
   end

   // One-cycle error flag for the word just sampled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= cnt_err;
      end
   end

   // Saturating error counter; a clear wins over a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (clr_cnt) begin
         err_count <= '0;
      end else if (cnt_err && (err_count != {CNT_W{1'b1}})) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

   // Saturating checked-bit counter; a clear wins over a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_count <= '0;
      end else if (clr_cnt) begin
         bit_count <= '0;
      end else if (cnt_bit && (bit_count != {CNT_W{1'b1}})) begin
         bit_count <= bit_count + CNT_W'(1);
      end
   end

   assign locked = (state == LOCK);

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed self-checking bench for prbs_checker

module tb_prbs_checker;

   localparam logic [31:0] SEED = 32'hB5538C9F;
`ifdef PRBS_OVERLAP_CHK_EN
   localparam int OVL_EXP = 1;
`else
   localparam int OVL_EXP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  data_in;
   logic        data_valid;
   logic        clr_cnt;
   logic        locked;
   logic        err_pulse;
   logic [31:0] err_count;
   logic [31:0] bit_count;
   logic        locked2;
   logic        err_pulse2;
   logic [3:0]  err_count2;
   logic [3:0]  bit_count2;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [4:0]  gw;
   logic [3:0]  sh;

   always #5 clk = ~clk;

   prbs_checker dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .clr_cnt    (clr_cnt),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .bit_count  (bit_count)
   );

   prbs_checker #(.LOSS_CNT(32), .CNT_W(4)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .clr_cnt    (clr_cnt),
      .locked     (locked2),
      .err_pulse  (err_pulse2),
      .err_count  (err_count2),
      .bit_count  (bit_count2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic [4:0] d, input logic v, input logic c);
      data_in    = d;
      data_valid = v;
      clr_cnt    = c;
      @(posedge clk);
      if (v) sh = {sh[2:0], d[4]};
      #1;
   endtask

   task automatic advance();
      gw = {~(gw[4] ^ gw[1]), gw[4:1]};
   endtask

   task automatic good_word();
      step(gw, 1'b1, 1'b0);
      advance();
   endtask

   initial begin
      int          m;
      int          nw;
      logic        mis;
      logic [31:0] exp_bits;
      logic [31:0] exp_err;
      logic [31:0] e0;
      logic [5:0]  pp;

      rst        = 1'b1;
      data_in    = 5'b0;
      data_valid = 1'b0;
      clr_cnt    = 1'b0;
      gw         = SEED[31:27];
      sh         = 4'b0;

      // 1: reset held while valid words arrive
      for (int i = 0; i < 6; i++) good_word();
      check("rst_locked", locked, 0);
      check("rst_pulse", err_pulse, 0);
      check("rst_err", err_count, 0);
      check("rst_bits", bit_count, 0);
      rst = 1'b0;
      gw  = SEED[31:27];

      // 2: clean stream, lock after word 20, then 100 counted bits
      for (int i = 1; i <= 19; i++) good_word();
      check("t2_unlocked_w19", locked, 0);
      good_word();
      check("t2_locked_w20", locked, 1);
      check("t2_bits_at_lock", bit_count, 0);
      for (int i = 0; i < 100; i++) good_word();
      check("t2_bits_100", bit_count, 100);
      check("t2_err_0", err_count, 0);
      check("t2_bits_sat4", bit_count2, 15);

      // 3: single flipped newest bit -> errors at that word, +1 and +4
      pp = '0;
      step(gw ^ 5'b10000, 1'b1, 1'b0);
      advance();
      pp[0] = err_pulse;
      for (int i = 1; i < 6; i++) begin
         good_word();
         pp[i] = err_pulse;
      end
      check("t3_pulses", pp, 6'b010011);
      check("t3_err", err_count, 3);
      check("t3_locked", locked, 1);
      for (int i = 0; i < 30; i++) good_word();
      check("t3_err_after", err_count, 3);
      check("t3_bits", bit_count, 136);

      // 4: all-zero words; lock drops on the 8th mismatch
      m        = 0;
      nw       = 0;
      exp_bits = 136;
      exp_err  = 3;
      while (m < 8 && nw < 40) begin
         mis = ~(sh[0] ^ sh[3]);
         step(5'b00000, 1'b1, 1'b0);
         nw++;
         exp_bits++;
         if (mis) begin
            m++;
            exp_err++;
         end
         check("t4_locked", locked, (m < 8) ? 1 : 0);
      end
      check("t4_err", err_count, exp_err);
      check("t4_bits", bit_count, exp_bits);
      for (int i = 0; i < 15; i++) step(5'b00000, 1'b1, 1'b0);
      check("t4_still_unlocked", locked, 0);
      check("t4_err_frozen", err_count, exp_err);
      check("t4_bits_frozen", bit_count, exp_bits);
      check("t6_err_sat", err_count2, 15);
      check("t6_locked2", locked2, 1);

      // Asynchronous reset while dut2 is locked
      rst = 1'b1;
      #2;
      check("async_rst_locked2", locked2, 0);
      check("async_rst_err2", err_count2, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      gw  = SEED[31:27];

      // 5: valid toggling gives the same lock point and counts
      for (int i = 1; i <= 20; i++) begin
         good_word();
         if (i == 19) check("t5_unlocked_w19", locked, 0);
         if (i == 20) check("t5_locked_w20", locked, 1);
         step(~gw, 1'b0, 1'b0);
         check("t5_idle_pulse", err_pulse, 0);
      end
      for (int i = 0; i < 100; i++) begin
         good_word();
         step(~gw, 1'b0, 1'b0);
      end
      check("t5_bits_100", bit_count, 100);
      check("t5_err_0", err_count, 0);

      // clr_cnt on an error word: clear wins, pulse still fires
      step(gw ^ 5'b10000, 1'b1, 1'b1);
      advance();
      check("clr_pulse", err_pulse, 1);
      check("clr_err", err_count, 0);
      check("clr_bits", bit_count, 0);
      good_word();
      check("clr_next_pulse", err_pulse, 1);
      check("clr_next_err", err_count, 1);
      for (int i = 0; i < 20; i++) good_word();
      check("clr_err_total", err_count, 2);

      // Lowest bit corrupted once: only the overlap check can see it
      e0 = err_count;
      step(gw ^ 5'b00001, 1'b1, 1'b0);
      advance();
      for (int i = 0; i < 5; i++) good_word();
      check("ovl_err_delta", err_count - e0, OVL_EXP);
      check("ovl_locked", locked, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
